// File: rtl/biometric_sequencer.sv
// biometric_sequencer: sequences one voice-biometric utterance (capture FFT frames,
// then optionally wait for a BLE verdict) and reports the result.
// Latency: gate opens 1 cycle after start; result/timeout pulse 1 cycle after the deciding event.
// Backpressure: passive monitor of the FFT handshake; start_in ignored unless IDLE and unlocked.
//
// Ports:
//   clk_in, rst_n_in           clock, synchronous active-low reset
//   start_in, enroll_in        utterance request and mode (1 = enroll, 0 = verify)
//   fft_valid/ready/last_in    monitored FFT stream handshake (a last-beat completes a frame)
//   ble_valid_in, ble_data_in  verdict byte from the bluetooth link (nonzero = match)
//   fft_gate_out               FFT stream enable, high only while capturing
//   write_enable_out           enroll/store level, high while capturing in enroll mode
//   busy_out                   high whenever not IDLE
//   frame_count_out            frames completed in this utterance
//   result_valid_out           one-cycle completion pulse
//   detected_out               latched verdict, held until the next accepted start
//   timeout_out                one-cycle pulse when no verdict arrived in time
//   locked_out_out             lockout active
//
// Optional feature: define BIOMETRIC_LOCKOUT_EN to lock out start requests for
// LOCKOUT_CYCLES after three consecutive failed verifications.

module biometric_sequencer #(
  parameter int FRAMES         = 8,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int LOCKOUT_CYCLES = 500_000_000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       start_in,
  input  logic       enroll_in,
  input  logic       fft_valid_in,
  input  logic       fft_ready_in,
  input  logic       fft_last_in,
  input  logic       ble_valid_in,
  input  logic [7:0] ble_data_in,
  output logic       fft_gate_out,
  output logic       write_enable_out,
  output logic       busy_out,
  output logic [7:0] frame_count_out,
  output logic       result_valid_out,
  output logic       detected_out,
  output logic       timeout_out,
  output logic       locked_out_out
);

  // Timer holds 0..TIMEOUT_CYCLES-1, so $clog2 bits are enough.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    FRAME_LAST  = 8'(FRAMES - 1);
  localparam logic [7:0]    FRAME_MAX   = 8'(FRAMES);

  if (FRAMES < 1 || FRAMES > 255) begin : g_bad_frames
    $error("biometric_sequencer: FRAMES must be 1..255");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("biometric_sequencer: TIMEOUT_CYCLES must be >= 1");
  end
  if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout
    $error("biometric_sequencer: LOCKOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CAPTURE     = 2'd1,
    WAIT_RESULT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          enroll_q;
  logic [7:0]    frame_count;
  logic [TW-1:0] timer;
  logic          detected;
  logic          result_valid;
  logic          timeout;
  logic          locked;

  logic          frame_beat;
  logic          start_accept;
  logic          frame_done;
  logic          verdict;
  logic          expire;

  assign frame_beat = fft_valid_in & fft_ready_in & fft_last_in;

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, decision strobes and state-decoded outputs
  always_comb begin
    state_next       = state;
    start_accept     = 1'b0;
    frame_done       = 1'b0;
    verdict          = 1'b0;
    expire           = 1'b0;
    fft_gate_out     = 1'b0;
    write_enable_out = 1'b0;
    busy_out         = 1'b0;
    case (state)
      IDLE: begin
        if (start_in && !locked) begin
          start_accept = 1'b1;
          state_next   = CAPTURE;
        end
      end
      CAPTURE: begin
        fft_gate_out     = 1'b1;
        write_enable_out = enroll_q;
        busy_out         = 1'b1;
        if (frame_beat && frame_count == FRAME_LAST) begin
          frame_done = 1'b1;
          state_next = enroll_q ? IDLE : WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        busy_out = 1'b1;
        // A verdict on the expiry cycle wins over the timeout.
        if (ble_valid_in) begin
          verdict    = 1'b1;
          state_next = IDLE;
        end else if (timer == TIMER_LAST) begin
          expire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: frame counter, verdict timer, result latches
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      enroll_q     <= 1'b0;
      frame_count  <= 8'd0;
      timer        <= '0;
      detected     <= 1'b0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      if (start_accept) begin
        enroll_q    <= enroll_in;
        frame_count <= 8'd0;
        detected    <= 1'b0;
      end
      if (state == CAPTURE && frame_beat && frame_count != FRAME_MAX) begin
        frame_count <= frame_count + 8'd1;
      end
      if (frame_done) begin
        timer <= '0;
        if (enroll_q) begin
          result_valid <= 1'b1;
          detected     <= 1'b0;
        end
      end
      if (state == WAIT_RESULT && !verdict && !expire) begin
        timer <= timer + 1'b1;
      end
      if (verdict) begin
        detected     <= |ble_data_in;
        result_valid <= 1'b1;
      end
      if (expire) begin
        detected     <= 1'b0;
        timeout      <= 1'b1;
        result_valid <= 1'b1;
      end
    end
  end

`ifdef BIOMETRIC_LOCKOUT_EN
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

  logic [1:0]    fail_count;
  logic [LW-1:0] lock_timer;
  logic          locked_q;
  logic          verify_pass;
  logic          verify_fail;

  // Only verify completions reach verdict/expire, so enroll never moves the count.
  assign verify_pass = verdict & (|ble_data_in);
  assign verify_fail = (verdict & ~(|ble_data_in)) | expire;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      fail_count <= 2'd0;
      lock_timer <= '0;
      locked_q   <= 1'b0;
    end else if (locked_q) begin
      if (lock_timer == LOCK_LAST) begin
        locked_q   <= 1'b0;
        lock_timer <= '0;
        fail_count <= 2'd0;
      end else begin
        lock_timer <= lock_timer + 1'b1;
      end
    end else if (verify_pass) begin
      fail_count <= 2'd0;
    end else if (verify_fail) begin
      fail_count <= fail_count + 2'd1;
      if (fail_count == 2'd2) begin
        // Lock asserts on the same edge that raises result_valid (IDLE entry).
        locked_q   <= 1'b1;
        lock_timer <= '0;
      end
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  assign frame_count_out  = frame_count;
  assign result_valid_out = result_valid;
  assign detected_out     = detected;
  assign timeout_out      = timeout;
  assign locked_out_out   = locked;

endmodule

// File: tb/tb_biometric_sequencer.sv
// tb_biometric_sequencer: self-checking bench for biometric_sequencer (FRAMES=2,
// TIMEOUT_CYCLES=16, LOCKOUT_CYCLES=32). Expected results are queued when an
// utterance is driven and compared when result_valid_out pulses.

module tb_biometric_sequencer;

  localparam int FRAMES  = 2;
  localparam int TIMEOUT = 16;
  localparam int LOCKOUT = 32;
`ifdef BIOMETRIC_LOCKOUT_EN
  localparam int EXP_LOCKED   = 1;
  localparam int EXP_ACCEPT_N = LOCKOUT + 1;
`else
  localparam int EXP_LOCKED   = 0;
  localparam int EXP_ACCEPT_N = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       enroll = 1'b0;
  logic       fft_valid = 1'b0;
  logic       fft_ready = 1'b0;
  logic       fft_last = 1'b0;
  logic       ble_valid = 1'b0;
  logic [7:0] ble_data = 8'd0;
  logic       fft_gate;
  logic       write_enable;
  logic       busy;
  logic [7:0] frame_count;
  logic       result_valid;
  logic       detected;
  logic       timeout;
  logic       locked_out;

  typedef struct packed {
    logic       det;
    logic       tmo;
    logic [7:0] fc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  biometric_sequencer #(
    .FRAMES(FRAMES), .TIMEOUT_CYCLES(TIMEOUT), .LOCKOUT_CYCLES(LOCKOUT)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .enroll_in(enroll),
    .fft_valid_in(fft_valid), .fft_ready_in(fft_ready), .fft_last_in(fft_last),
    .ble_valid_in(ble_valid), .ble_data_in(ble_data),
    .fft_gate_out(fft_gate), .write_enable_out(write_enable), .busy_out(busy),
    .frame_count_out(frame_count), .result_valid_out(result_valid),
    .detected_out(detected), .timeout_out(timeout), .locked_out_out(locked_out)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (rst_n) begin
      if (result_valid) begin
        check("sb_has_entry", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_detected", int'(detected), int'(e.det));
          check("sb_timeout", int'(timeout), int'(e.tmo));
          check("sb_frames", int'(frame_count), int'(e.fc));
        end
      end else if (timeout) begin
        check("timeout_without_result", int'(timeout), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic en);
    start = 1'b1; enroll = en;
    tick();
    start = 1'b0; enroll = 1'b0;
  endtask

  task automatic beat(input logic last);
    fft_valid = 1'b1; fft_ready = 1'b1; fft_last = last;
    tick();
    fft_valid = 1'b0; fft_ready = 1'b0; fft_last = 1'b0;
  endtask

  task automatic ble(input logic [7:0] d);
    ble_valid = 1'b1; ble_data = d;
    tick();
    ble_valid = 1'b0; ble_data = 8'd0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gate"}, int'(fft_gate), 0);
    check({tag, "_we"}, int'(write_enable), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_fc"}, int'(frame_count), 0);
    check({tag, "_rv"}, int'(result_valid), 0);
    check({tag, "_det"}, int'(detected), 0);
    check({tag, "_tmo"}, int'(timeout), 0);
    check({tag, "_lock"}, int'(locked_out), 0);
  endtask

  initial begin
    int n;
    tick();
    tick();
    rst_n = 1'b1;
    check_all_zero("reset");

    // Verify with a match
    do_start(1'b0);
    check("v_gate_on", int'(fft_gate), 1);
    check("v_busy", int'(busy), 1);
    check("v_we_off", int'(write_enable), 0);
    beat(1'b1);
    check("v_fc1", int'(frame_count), 1);
    beat(1'b1);
    check("v_gate_off_wait", int'(fft_gate), 0);
    check("v_busy_wait", int'(busy), 1);
    check("v_fc2", int'(frame_count), 2);
    sb.push_back('{det: 1'b1, tmo: 1'b0, fc: 8'd2});
    ble(8'h01);
    check("v_rv", int'(result_valid), 1);
    check("v_idle", int'(busy), 0);
    tick();
    check("v_rv_one_cycle", int'(result_valid), 0);
    check("v_det_held", int'(detected), 1);

    // Stale verdict byte while idle
    ble(8'h00);
    check("idle_ble_det", int'(detected), 1);
    check("idle_ble_rv", int'(result_valid), 0);

    // Enroll
    do_start(1'b1);
    check("e_det_cleared", int'(detected), 0);
    check("e_we_on", int'(write_enable), 1);
    ble(8'hFF);
    check("e_ble_ignored_busy", int'(busy), 1);
    check("e_ble_ignored_fc", int'(frame_count), 0);
    beat(1'b0);
    check("e_nonlast_fc", int'(frame_count), 0);
    beat(1'b1);
    check("e_fc1", int'(frame_count), 1);
    check("e_we_mid", int'(write_enable), 1);
    sb.push_back('{det: 1'b0, tmo: 1'b0, fc: 8'd2});
    beat(1'b1);
    check("e_rv", int'(result_valid), 1);
    check("e_we_off", int'(write_enable), 0);
    check("e_gate_off", int'(fft_gate), 0);
    check("e_idle", int'(busy), 0);
    tick();

    // Timeout latency
    do_start(1'b0);
    beat(1'b1);
    beat(1'b1);
    sb.push_back('{det: 1'b0, tmo: 1'b1, fc: 8'd2});
    n = 0;
    while (!result_valid && n < 3 * TIMEOUT) begin
      tick();
      n++;
    end
    check("t_latency", n, TIMEOUT);
    check("t_pulse", int'(timeout), 1);
    tick();
    check("t_pulse_one_cycle", int'(timeout), 0);

    // Verdict on the expiry cycle beats the timeout
    do_start(1'b0);
    beat(1'b1);
    beat(1'b1);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("tv_still_waiting", int'(busy), 1);
    sb.push_back('{det: 1'b1, tmo: 1'b0, fc: 8'd2});
    ble(8'h05);
    check("tv_rv", int'(result_valid), 1);
    check("tv_no_timeout", int'(timeout), 0);
    tick();

    // Ignored start, then reset mid-capture
    do_start(1'b0);
    beat(1'b1);
    do_start(1'b1);
    check("is_fc", int'(frame_count), 1);
    check("is_gate", int'(fft_gate), 1);
    check("is_we", int'(write_enable), 0);
    pulse_reset();
    check_all_zero("midrst");
    do_start(1'b0);
    beat(1'b1);
    beat(1'b1);
    sb.push_back('{det: 1'b0, tmo: 1'b0, fc: 8'd2});
    ble(8'h00);
    check("fresh_rv", int'(result_valid), 1);
    tick();

    // Three failed verifications, then lockout window
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      do_start(1'b0);
      beat(1'b1);
      beat(1'b1);
      sb.push_back('{det: 1'b0, tmo: 1'b0, fc: 8'd2});
      ble(8'h00);
      if (k < 2) begin
        check("lk_not_yet", int'(locked_out), 0);
        tick();
      end
    end
    check("lk_locked", int'(locked_out), EXP_LOCKED);
    start = 1'b1;
    n = 0;
    while (!busy && n < 4 * LOCKOUT) begin
      tick();
      n++;
    end
    start = 1'b0;
    check("lk_accept_delay", n, EXP_ACCEPT_N);
    check("lk_released", int'(locked_out), 0);
    pulse_reset();
    tick();

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
